app_capture_fifo: RTL and testbench



---
 rtl/app_capture_pkg.sv | 24 ++
 rtl/app_capture_fifo_if.sv | 24 ++
 rtl/capture_sync_fifo.sv | 52 +++++
 rtl/app_capture_fifo.sv | 155 +++++++++++++++
 tb/tb_app_capture_fifo.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/app_capture_pkg.sv
// Shared types and constants for the application capture buffer.
// State encoding, local-bus register offsets and STATUS bit positions.
package app_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMED     = 2'd1,
    ST_CAPTURING = 2'd2,
    ST_DONE      = 2'd3
  } cap_state_e;

  localparam logic [3:0] OFF_CTRL     = 4'h0;
  localparam logic [3:0] OFF_LEN      = 4'h1;
  localparam logic [3:0] OFF_STATUS   = 4'h2;
  localparam logic [3:0] OFF_DATA     = 4'h3;
  localparam logic [3:0] OFF_CAPTURED = 4'h4;

  localparam int STS_OVF   = 31;
  localparam int STS_FULL  = 30;
  localparam int STS_EMPTY = 29;
  localparam int STS_UNF   = 28;
  localparam int STS_STATE = 16;

endpackage

// File: rtl/app_capture_fifo_if.sv
// Local-bus slice seen by the capture buffer.
// The host drives address/strobes/write data; the block returns read data.
interface app_capture_fifo_if;

  logic [23:0] lb_addr;
  logic        lb_strobe;
  logic        lb_rd;
  logic        lb_write;
  logic [31:0] lb_data_out;
  logic [31:0] lb_data_in;

  modport master (
    output lb_addr, lb_strobe, lb_rd,
    output lb_write, lb_data_out,
    input  lb_data_in
  );

  modport slave (
    input  lb_addr, lb_strobe, lb_rd,
    input  lb_write, lb_data_out,
    output lb_data_in
  );

endinterface

// File: rtl/capture_sync_fifo.sv
// Single-clock FIFO with occupancy count and registered-read RAM.
// Pop while empty and push while full (without pop) are ignored here.
module capture_sync_fifo #(
  parameter int AW = 9,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  assign empty = (count == '0);
  assign full  = count[AW];
  assign rd_en = pop & ~empty;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts.
  assign wr_en = push & (~full | rd_en);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
    dout <= mem[rd_ptr];
  end

endmodule

// File: rtl/app_capture_fifo.sv
// Arm/trigger sample capture into a FIFO, drained over the local bus.
// Read data returns two cycles after the selected strobe.
module app_capture_fifo
  import app_capture_pkg::*;
#(
  parameter int          AW         = 9,
  parameter logic [3:0]  REGION     = 4'h1,
  parameter logic [31:0] EMPTY_WORD = 32'h0
) (
  input  logic               clk,
  input  logic               rst_n,
  app_capture_fifo_if.slave  lb,
  input  logic [31:0]        sample_data,
  input  logic               sample_valid,
  input  logic               trigger,
  output logic               capture_busy
);

  cap_state_e  state_q, state_d;
  logic [15:0] len_q;
  logic [15:0] cnt_q;
  logic        ovf_q, unf_q;
  logic        sel, bus_wr, bus_rd;
  logic [3:0]  off;
  logic        arm, clr, pop, push, arm_ok;
  logic        fifo_full, fifo_empty;
  logic [AW:0] fifo_cnt;
  logic [31:0] fifo_dout;
  logic [31:0] status, rd_mux;
  logic        rd1_v, rd1_ram;
  logic [31:0] rd1_val;

  assign sel    = lb.lb_strobe && (lb.lb_addr[23:20] == REGION);
  assign off    = lb.lb_addr[3:0];
  assign bus_wr = sel & lb.lb_write;
  assign bus_rd = sel & lb.lb_rd;
  assign pop    = bus_rd && (off == OFF_DATA);
  assign clr    = bus_wr && (off == OFF_CTRL) && lb.lb_data_out[1];
  assign arm    = bus_wr && (off == OFF_CTRL) && lb.lb_data_out[0];

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    arm_ok  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm && len_q != '0) begin
          state_d = ST_ARMED;
          arm_ok  = 1'b1;
        end
      end
      ST_ARMED: begin
        if (sample_valid && trigger) begin
          push    = 1'b1;
          state_d = (len_q <= 16'd1) ? ST_DONE
                                     : ST_CAPTURING;
        end
      end
      ST_CAPTURING: begin
        if (sample_valid) begin
          push = 1'b1;
          if (cnt_q + 16'd1 >= len_q)
            state_d = ST_DONE;
        end
      end
      default: ;
    endcase
    if (clr) begin
      state_d = ST_IDLE;
      push    = 1'b0;
      arm_ok  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q        <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      capture_busy <= 1'b0;
    end else begin
      capture_busy <= (state_q == ST_ARMED) ||
                      (state_q == ST_CAPTURING);
      if (bus_wr && off == OFF_LEN)
        len_q <= lb.lb_data_out[15:0];
      if (clr || arm_ok) cnt_q <= '0;
      else if (push)     cnt_q <= cnt_q + 16'd1;
      if (clr) begin
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
      end else begin
        if (push && fifo_full && !pop) ovf_q <= 1'b1;
        if (pop && fifo_empty)         unf_q <= 1'b1;
      end
    end
  end

  capture_sync_fifo #(.AW(AW), .DW(32)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (clr),
    .push  (push),
    .din   (sample_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  always_comb begin
    status                  = '0;
    status[STS_OVF]         = ovf_q;
    status[STS_FULL]        = fifo_full;
    status[STS_EMPTY]       = fifo_empty;
    status[STS_UNF]         = unf_q;
    status[STS_STATE +: 2]  = state_q;
    status[AW:0]            = fifo_cnt;
  end

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      off == OFF_CTRL:     rd_mux = {30'b0, state_q};
      off == OFF_LEN:      rd_mux = {16'b0, len_q};
      off == OFF_STATUS:   rd_mux = status;
      off == OFF_DATA:     rd_mux = EMPTY_WORD;
      off == OFF_CAPTURED: rd_mux = {16'b0, cnt_q};
      default: ;
    endcase
  end

  // Stage 1 snapshots registers; DATA waits for the registered RAM word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd1_v         <= 1'b0;
      rd1_ram       <= 1'b0;
      rd1_val       <= '0;
      lb.lb_data_in <= '0;
    end else begin
      rd1_v   <= bus_rd;
      rd1_ram <= pop && !fifo_empty;
      if (bus_rd) rd1_val <= rd_mux;
      if (rd1_v)
        lb.lb_data_in <= rd1_ram ? fifo_dout : rd1_val;
    end
  end

endmodule

// File: tb/tb_app_capture_fifo.sv
// Directed bench for app_capture_fifo with a 4-deep FIFO.
// Expected values are hand-computed per step.
module tb_app_capture_fifo;

  localparam logic [31:0] EW = 32'hE0E0_E0E0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] sample_data;
  logic        sample_valid;
  logic        trigger;
  logic        capture_busy;

  int n_chk = 0;
  int n_err = 0;

  logic [3:0]  boff [4];
  logic [31:0] bexp [4];

  app_capture_fifo_if bus ();

  app_capture_fifo #(
    .AW(2), .REGION(4'h1), .EMPTY_WORD(EW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lb           (bus),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .trigger      (trigger),
    .capture_busy (capture_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.lb_strobe = 1'b0;
    bus.lb_rd     = 1'b0;
    bus.lb_write  = 1'b0;
  endtask

  task automatic set_rd(input logic [3:0] o);
    bus.lb_addr   = {4'h1, 16'h0, o};
    bus.lb_strobe = 1'b1;
    bus.lb_rd     = 1'b1;
    bus.lb_write  = 1'b0;
  endtask

  task automatic wr(input logic [3:0] o,
                    input logic [31:0] d);
    bus.lb_addr     = {4'h1, 16'h0, o};
    bus.lb_data_out = d;
    bus.lb_strobe   = 1'b1;
    bus.lb_rd       = 1'b0;
    bus.lb_write    = 1'b1;
    tick();
    bus_idle();
  endtask

  task automatic rd(input logic [3:0] o,
                    output logic [31:0] d);
    set_rd(o);
    tick();
    bus_idle();
    tick();
    d = bus.lb_data_in;
  endtask

  task automatic smp(input logic [31:0] d,
                     input logic t);
    sample_valid = 1'b1;
    sample_data  = d;
    trigger      = t;
    tick();
    sample_valid = 1'b0;
    trigger      = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    bus.lb_addr     = '0;
    bus.lb_data_out = '0;
    bus_idle();
    sample_data  = '0;
    sample_valid = 1'b0;
    trigger      = 1'b0;
    rst_n        = 1'b0;
    repeat (3) tick();
    chk("rst_data", bus.lb_data_in, 32'h0);
    chk("rst_busy", {31'b0, capture_busy}, 32'h0);
    rst_n = 1'b1;
    tick();
    rd(4'h2, v); chk("rst_status", v, 32'h2000_0000);
    rd(4'h1, v); chk("rst_len", v, 32'h0);

    wr(4'h0, 32'h1);
    rd(4'h0, v); chk("arm_len0", v, 32'h0);

    // basic capture
    wr(4'h1, 32'h4);
    rd(4'h1, v); chk("len4", v, 32'h4);
    wr(4'h0, 32'h1);
    rd(4'h0, v); chk("armed", v, 32'h1);
    chk("busy_on", {31'b0, capture_busy}, 32'h1);
    for (int i = 0; i < 8; i++)
      smp(32'hA0 + i, i == 2);
    rd(4'h4, v); chk("capt4", v, 32'h4);
    rd(4'h2, v); chk("sts_full", v, 32'h4003_0004);
    chk("busy_off", {31'b0, capture_busy}, 32'h0);
    set_rd(4'h3);
    tick();
    chk("lat_t1", bus.lb_data_in, 32'h4003_0004);
    bus_idle();
    tick();
    chk("lat_t2", bus.lb_data_in, 32'hA2);
    for (int i = 1; i < 4; i++) begin
      rd(4'h3, v);
      chk($sformatf("data_a%0d", i), v, 32'hA2 + i);
    end
    rd(4'h2, v); chk("sts_drained", v, 32'h2003_0000);

    // underflow then clear
    rd(4'h3, v); chk("unf_word", v, EW);
    rd(4'h2, v); chk("unf_sts", v, 32'h3003_0000);
    wr(4'h0, 32'h2);
    rd(4'h2, v); chk("clr_sts", v, 32'h2000_0000);

    // overflow
    wr(4'h1, 32'h6);
    wr(4'h0, 32'h1);
    for (int i = 0; i < 6; i++)
      smp(32'hB0 + i, i == 0);
    rd(4'h4, v); chk("capt6", v, 32'h6);
    rd(4'h2, v); chk("ovf_sts", v, 32'hC003_0004);
    for (int i = 0; i < 4; i++) begin
      rd(4'h3, v);
      chk($sformatf("data_b%0d", i), v, 32'hB0 + i);
    end
    rd(4'h2, v); chk("ovf_drained", v, 32'hA003_0000);
    wr(4'h0, 32'h2);

    // simultaneous push/pop on a full FIFO
    wr(4'h1, 32'd10);
    wr(4'h0, 32'h1);
    for (int i = 0; i < 4; i++)
      smp(32'hC0 + i, i == 0);
    rd(4'h2, v); chk("pp_pre", v, 32'h4002_0004);
    set_rd(4'h3);
    sample_valid = 1'b1;
    sample_data  = 32'hC4;
    tick();
    bus_idle();
    sample_valid = 1'b0;
    tick();
    chk("pp_word", bus.lb_data_in, 32'hC0);
    rd(4'h2, v); chk("pp_post", v, 32'h4002_0004);
    rd(4'h4, v); chk("pp_capt", v, 32'h5);

    // back-to-back reads
    boff = '{4'h1, 4'h3, 4'h3, 4'h2};
    bexp = '{32'd10, 32'hC1, 32'hC2, 32'h0002_0002};
    for (int j = 0; j < 5; j++) begin
      if (j < 4) set_rd(boff[j]);
      else       bus_idle();
      tick();
      if (j >= 1)
        chk($sformatf("b2b_%0d", j - 1),
            bus.lb_data_in, bexp[j - 1]);
    end
    bus_idle();

    // arm and clear together
    wr(4'h0, 32'h3);
    rd(4'h2, v); chk("armclr_sts", v, 32'h2000_0000);

    // reset while capturing, with a read in flight
    wr(4'h1, 32'h5);
    wr(4'h0, 32'h1);
    smp(32'hD0, 1'b1);
    smp(32'hD1, 1'b0);
    rd(4'h0, v); chk("capturing", v, 32'h2);
    rd(4'h1, v); chk("len5", v, 32'h5);
    set_rd(4'h4);
    tick();
    bus_idle();
    rst_n = 1'b0;
    tick();
    chk("rst_mid_data", bus.lb_data_in, 32'h0);
    chk("rst_mid_busy", {31'b0, capture_busy}, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("rst_stale", bus.lb_data_in, 32'h0);
    rd(4'h2, v); chk("rst2_sts", v, 32'h2000_0000);
    rd(4'h1, v); chk("rst2_len", v, 32'h0);
    rd(4'h4, v); chk("rst2_capt", v, 32'h0);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
